// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter with a bounded hold time per owner.
// It drives a registered one-hot grant and a mux select, and Z returns the owner's data bit.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] X,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       Z,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [2:0] MAX_HOLD_C = 3'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [1:0] s_reg, s_next;
  logic [3:0] gnt_reg, gnt_next;

  logic [3:0] owner_mask;
  logic [3:0] req_others;
  logic [3:0] rot_all;
  logic [3:0] rot_oth;
  logic [1:0] win_all;
  logic [1:0] win_oth;

  // Position of the first set bit, counting up from bit 0.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign owner_mask = 4'b0001 << last_reg;
  assign req_others = req & ~owner_mask;

  // Rotate the requests so that bit 0 holds source last+1 and bit 3 holds source last+4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFF = 2'(gi + 1);
      assign rot_all[gi] = req[last_reg + OFF];
      assign rot_oth[gi] = req_others[last_reg + OFF];
    end
  endgenerate

  assign win_all = last_reg + first_set(rot_all) + 2'd1;
  assign win_oth = last_reg + first_set(rot_oth) + 2'd1;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    s_next     = s_reg;
    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          last_next  = win_all;
          s_next     = win_all;
          cnt_next   = 3'd1;
        end
      end
      GRANT: begin
        if (req == 4'b0000) begin
          state_next = IDLE;
        end else if (req[last_reg]) begin
          if (cnt_reg < MAX_HOLD_C) begin
            cnt_next = cnt_reg + 3'd1;
          end else begin
            // The hold has expired: hand over if anyone else is waiting, otherwise restart it.
            if (|req_others) begin
              last_next = win_oth;
              s_next    = win_oth;
            end
            cnt_next = 3'd1;
          end
        end else begin
          last_next = win_all;
          s_next    = win_all;
          cnt_next  = 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    gnt_next = (state_next == GRANT) ? (4'b0001 << last_next) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 2'b11;
      cnt_reg   <= 3'd0;
      s_reg     <= 2'b00;
      gnt_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
      gnt_reg   <= gnt_next;
    end
  end

  assign gnt  = gnt_reg;
  assign S    = s_reg;
  assign busy = (state_reg == GRANT);
  assign Z    = busy & X[s_reg];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: a table of directed vectors, hand-written corner sequences,
// and random traffic checked against a rule-level reference model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] X;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       Z;
  logic       busy;

  int checks;
  int errors;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .X   (X),
    .gnt (gnt),
    .S   (S),
    .Z   (Z),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       z;
  } vec_t;

  vec_t tbl[16];

  // Reference model state: the arbitration rules expressed in terms of owners and hold time.
  bit m_busy;
  int m_last;
  int m_cnt;
  int m_s;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    X   = 4'b0000;
    step();
    rst = 1'b0;
    m_busy = 1'b0;
    m_last = 3;
    m_cnt  = 0;
    m_s    = 0;
  endtask

  // The first requesting source found walking from after 'from', skipping 'skip'.
  function automatic int rr_pick(input int from, input logic [3:0] r, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (from + k) % 4;
      if (r[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r);
    int w;
    if (!m_busy) begin
      if (r != 0) begin
        w = rr_pick(m_last, r, -1);
        m_busy = 1'b1; m_last = w; m_s = w; m_cnt = 1;
      end
    end else if (r == 0) begin
      m_busy = 1'b0;
    end else if (r[m_last]) begin
      if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end else begin
        w = rr_pick(m_last, r, m_last);
        if (w >= 0) begin
          m_last = w; m_s = w;
        end
        m_cnt = 1;
      end
    end else begin
      w = rr_pick(m_last, r, -1);
      m_last = w; m_s = w; m_cnt = 1;
    end
  endtask

  initial begin
    logic [3:0] exp_gnt;
    logic       exp_z;
    logic [3:0] r;
    int         sel;

    checks = 0;
    errors = 0;

    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[6]  = '{4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{4'b1100, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[9]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[13] = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[14] = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[15] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0};

    // Reset state, sampled while rst is still high.
    rst = 1'b1;
    req = 4'b0000;
    X   = 4'b1111;
    #3;
    chk("reset_gnt", 8'(gnt), 8'h0);
    chk("reset_S", 8'(S), 8'h0);
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_Z", 8'(Z), 8'h0);

    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req;
      X   = tbl[i].x;
      step();
      chk($sformatf("tbl%0d_gnt", i), 8'(gnt), 8'(tbl[i].gnt));
      chk($sformatf("tbl%0d_S", i), 8'(S), 8'(tbl[i].s));
      chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].busy));
      chk($sformatf("tbl%0d_Z", i), 8'(Z), 8'(tbl[i].z));
      $display("vec %0d req=%b X=%b gnt=%b S=%0d busy=%b Z=%b", i, req, X, gnt, S, busy, Z);
    end

    // A lone requester keeps its grant past the hold limit with no gap.
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("solo%0d_gnt", c), 8'(gnt), 8'h04);
      chk($sformatf("solo%0d_S", c), 8'(S), 8'h2);
      $display("solo cycle %0d gnt=%b S=%0d", c, gnt, S);
    end

    // Z follows X without a clock edge.
    do_reset();
    req = 4'b0001;
    X   = 4'b0001;
    step();
    chk("zcomb_gnt", 8'(gnt), 8'h01);
    chk("zcomb_high", 8'(Z), 8'h1);
    #2;
    X = 4'b0000;
    #1;
    chk("zcomb_low", 8'(Z), 8'h0);
    $display("zcomb Z after X drop=%b", Z);

    // Reset in the middle of a grant clears outputs before the next edge.
    do_reset();
    req = 4'b0010;
    step();
    chk("midrst_pre_gnt", 8'(gnt), 8'h02);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 8'(gnt), 8'h0);
    chk("midrst_S", 8'(S), 8'h0);
    chk("midrst_busy", 8'(busy), 8'h0);
    step();
    #2;
    rst = 1'b0;
    m_busy = 1'b0; m_last = 3; m_cnt = 0; m_s = 0;
    step();
    chk("midrst_regrant", 8'(gnt), 8'h02);
    chk("midrst_regrant_S", 8'(S), 8'h1);
    $display("midrst regrant gnt=%b S=%0d", gnt, S);
    model_edge(4'b0010);

    // Random traffic against the reference model.
    r = 4'b0010;
    for (int c = 0; c < 400; c++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) r = r;
      else if (sel < 5) r = 4'b0000;
      else r = 4'($urandom);
      req = r;
      X   = 4'($urandom);
      step();
      model_edge(r);
      exp_gnt = m_busy ? (4'b0001 << m_s) : 4'b0000;
      exp_z   = m_busy ? X[m_s] : 1'b0;
      chk($sformatf("rnd%0d_gnt", c), 8'(gnt), 8'(exp_gnt));
      chk($sformatf("rnd%0d_S", c), 8'(S), 8'(m_s));
      chk($sformatf("rnd%0d_busy", c), 8'(busy), 8'(m_busy));
      chk($sformatf("rnd%0d_Z", c), 8'(Z), 8'(exp_z));
      chk($sformatf("rnd%0d_onehot", c), 8'($countones(gnt) <= 1), 8'h1);
      $display("rnd %0d req=%b gnt=%b S=%0d busy=%b Z=%b", c, req, gnt, S, busy, Z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
